// File: rtl/led_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module  : led_pattern_gen
// Brief   : Parametrised status-LED pattern generator (binary/Gray/scan/PWM).
// Revision: 1.0 - initial release
// ============================================================================
module led_pattern_gen #(
    parameter int N_LEDS    = 4,
    parameter int LOG2DELAY = 21,
    parameter int PWM_BITS  = 4
) (
    input  logic              clki,
    input  logic              rst,
    input  logic [1:0]        mode,
    output logic [N_LEDS-1:0] led,
    output logic              step,
    output logic [1:0]        mode_q
);

    localparam logic [1:0] c_MODE_BIN  = 2'd0;
    localparam logic [1:0] c_MODE_GRAY = 2'd1;
    localparam logic [1:0] c_MODE_SCAN = 2'd2;
    localparam logic [1:0] c_MODE_BRTH = 2'd3;

    // A single LED still needs a 1-bit position register.
    localparam int                   c_POS_W    = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;
    localparam logic [c_POS_W-1:0]   c_POS_MAX  = c_POS_W'(N_LEDS - 1);
    localparam logic [PWM_BITS-1:0]  c_DUTY_MAX = '1;

    logic [LOG2DELAY-1:0] r_pre;
    logic [PWM_BITS-1:0]  r_pwm;
    logic [N_LEDS-1:0]    r_cnt;
    logic [c_POS_W-1:0]   r_pos;
    logic                 r_dir;
    logic [PWM_BITS-1:0]  r_duty;
    logic                 r_ddir;
    logic [1:0]           r_mode_q;
    logic [N_LEDS-1:0]    r_led;

    logic                 w_step;
    logic [c_POS_W-1:0]   w_pos_inc;
    logic [c_POS_W-1:0]   w_pos_dec;
    logic [PWM_BITS-1:0]  w_duty_inc;
    logic [PWM_BITS-1:0]  w_duty_dec;

    assign w_step     = &r_pre;
    assign w_pos_inc  = r_pos + c_POS_W'(1);
    assign w_pos_dec  = r_pos - c_POS_W'(1);
    assign w_duty_inc = r_duty + PWM_BITS'(1);
    assign w_duty_dec = r_duty - PWM_BITS'(1);

    always_ff @(posedge clki or posedge rst) begin
        if (rst) begin
            r_pre <= '0;
            r_pwm <= '0;
        end else begin
            r_pre <= r_pre + LOG2DELAY'(1);
            r_pwm <= r_pwm + PWM_BITS'(1);
        end
    end

    // A mode request is only honoured on a step edge; that edge restarts the pattern.
    always_ff @(posedge clki or posedge rst) begin
        if (rst) begin
            r_mode_q <= c_MODE_BIN;
            r_cnt    <= '0;
            r_pos    <= '0;
            r_dir    <= 1'b0;
            r_duty   <= '0;
            r_ddir   <= 1'b0;
        end else if (w_step) begin
            if (mode != r_mode_q) begin
                r_mode_q <= mode;
                r_cnt    <= '0;
                r_pos    <= '0;
                r_dir    <= 1'b0;
                r_duty   <= '0;
                r_ddir   <= 1'b0;
            end else begin
                case (r_mode_q)
                    c_MODE_BIN, c_MODE_GRAY: begin
                        r_cnt <= r_cnt + N_LEDS'(1);
                    end
                    c_MODE_SCAN: begin
                        if (N_LEDS > 1) begin
                            if (!r_dir) begin
                                r_pos <= w_pos_inc;
                                if (w_pos_inc == c_POS_MAX) r_dir <= 1'b1;
                            end else begin
                                r_pos <= w_pos_dec;
                                if (w_pos_dec == '0) r_dir <= 1'b0;
                            end
                        end
                    end
                    c_MODE_BRTH: begin
                        if (!r_ddir) begin
                            r_duty <= w_duty_inc;
                            if (w_duty_inc == c_DUTY_MAX) r_ddir <= 1'b1;
                        end else begin
                            r_duty <= w_duty_dec;
                            if (w_duty_dec == '0) r_ddir <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clki or posedge rst) begin
        if (rst) begin
            r_led <= '0;
        end else begin
            case (r_mode_q)
                c_MODE_BIN:  r_led <= r_cnt;
                c_MODE_GRAY: r_led <= r_cnt ^ (r_cnt >> 1);
                c_MODE_SCAN: r_led <= N_LEDS'(1) << r_pos;
                c_MODE_BRTH: r_led <= {N_LEDS{(r_pwm < r_duty)}};
                default:     r_led <= '0;
            endcase
        end
    end

    assign led    = r_led;
    assign step   = w_step;
    assign mode_q = r_mode_q;

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module  : tb_led_pattern_gen
// Brief   : Directed self-checking bench for led_pattern_gen.
// Revision: 1.0 - initial release
// ============================================================================
module tb_led_pattern_gen;

    localparam int N_LEDS    = 4;
    localparam int LOG2DELAY = 2;
    localparam int PWM_BITS  = 2;

    logic              clki = 1'b0;
    logic              rst  = 1'b1;
    logic [1:0]        mode = 2'd0;
    logic [N_LEDS-1:0] led;
    logic              step;
    logic [1:0]        mode_q;

    logic [1:0]        mode1 = 2'd2;
    logic [0:0]        led1;
    logic              step1;
    logic [1:0]        mode_q1;

    int n_checks = 0;
    int n_errors = 0;
    int k        = 0;   // index of the next clock edge since reset release

    logic [3:0] gray_tab [9] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110,
                                 4'b0111, 4'b0101, 4'b0100, 4'b1100};
    logic [3:0] scan_tab [9] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100,
                                 4'b0010, 4'b0001, 4'b0010, 4'b0100};
    int         duty_tab [8] = '{0, 1, 2, 3, 2, 1, 0, 1};

    always #5 clki = ~clki;

    led_pattern_gen #(
        .N_LEDS   (N_LEDS),
        .LOG2DELAY(LOG2DELAY),
        .PWM_BITS (PWM_BITS)
    ) u_dut (
        .clki  (clki),
        .rst   (rst),
        .mode  (mode),
        .led   (led),
        .step  (step),
        .mode_q(mode_q)
    );

    led_pattern_gen #(
        .N_LEDS   (1),
        .LOG2DELAY(LOG2DELAY),
        .PWM_BITS (PWM_BITS)
    ) u_dut1 (
        .clki  (clki),
        .rst   (rst),
        .mode  (mode1),
        .led   (led1),
        .step  (step1),
        .mode_q(mode_q1)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s (edge %0d): got %0h expected %0h", tag, k, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clki);
            k++;
        end
    endtask

    task automatic go_to(input int target);
        while (k < target) tick(1);
    endtask

    task automatic do_reset(input logic [1:0] m);
        @(negedge clki);
        rst  = 1'b1;
        mode = m;
        tick(2);
        rst  = 1'b0;
        k    = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int ones;

        // Reset values while reset is held
        @(negedge clki);
        check_eq("rst_led",    32'(led),    32'h0);
        check_eq("rst_mode_q", 32'(mode_q), 32'h0);
        check_eq("rst_step",   32'(step),   32'h0);
        check_eq("rst_led1",   32'(led1),   32'h0);

        // Binary count and step period, including wrap of cnt
        do_reset(2'd0);
        check_eq("bin_led0",    32'(led),    32'h0);
        check_eq("bin_mode_q0", 32'(mode_q), 32'h0);
        for (int i = 0; i < 70; i++) begin
            go_to(i);
            check_eq("bin_step", 32'(step), 32'((i % 4) == 3));
            if (i >= 1) check_eq("bin_led", 32'(led), 32'(((i - 1) / 4) % 16));
        end

        // Gray count
        do_reset(2'd1);
        go_to(3);
        check_eq("gray_mq_before", 32'(mode_q), 32'h0);
        go_to(4);
        check_eq("gray_mq_after", 32'(mode_q), 32'h1);
        for (int j = 1; j <= 9; j++) begin
            go_to(4 * j + 1);
            check_eq("gray_led", 32'(led), 32'(gray_tab[j-1]));
        end

        // Scanner bounce, plus the single-LED instance
        do_reset(2'd2);
        for (int j = 1; j <= 9; j++) begin
            go_to(4 * j + 1);
            check_eq("scan_led",  32'(led),  32'(scan_tab[j-1]));
            check_eq("scan1_led", 32'(led1), 32'h1);
        end

        // Breathe: on-cycles per 4-cycle window equals duty
        do_reset(2'd3);
        for (int j = 1; j <= 8; j++) begin
            ones = 0;
            for (int s = 1; s <= 4; s++) begin
                go_to(4 * j + s);
                check_eq("brth_uniform", 32'((led == 4'h0) || (led == 4'hF)), 32'h1);
                if (led == 4'hF) ones++;
            end
            check_eq("brth_ones", ones, duty_tab[j-1]);
        end

        // Mode pulse between steps is ignored; held change takes effect at step
        do_reset(2'd0);
        go_to(4);
        mode = 2'd2;
        go_to(6);
        mode = 2'd0;
        go_to(8);
        check_eq("mchg_mq_kept", 32'(mode_q), 32'h0);
        go_to(9);
        check_eq("mchg_cnt2", 32'(led), 32'h2);
        mode = 2'd1;
        go_to(10);
        check_eq("mchg_mq_wait", 32'(mode_q), 32'h0);
        go_to(12);
        check_eq("mchg_mq_new", 32'(mode_q), 32'h1);
        check_eq("mchg_led_old", 32'(led), 32'h2);
        go_to(13);
        check_eq("mchg_led_new", 32'(led), 32'h0);

        // Asynchronous reset mid-operation in scanner mode at pos=2
        do_reset(2'd2);
        go_to(13);
        check_eq("rstm_pos2", 32'(led), 32'h4);
        #2;
        rst = 1'b1;
        #1;
        check_eq("rstm_led",    32'(led),    32'h0);
        check_eq("rstm_mode_q", 32'(mode_q), 32'h0);
        check_eq("rstm_step",   32'(step),   32'h0);
        @(negedge clki);
        rst = 1'b0;
        k   = 0;
        for (int i = 0; i <= 4; i++) begin
            go_to(i);
            check_eq("rstm_step_seq", 32'(step), 32'(i == 3));
        end
        go_to(5);
        check_eq("rstm_led_after", 32'(led),    32'h1);
        check_eq("rstm_mq_after",  32'(mode_q), 32'h2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/led_pattern_gen.md
# led_pattern_gen

Parametrised LED pattern generator driving a bank of status LEDs on the xc7 test designs. It extends the fixed 4-LED Gray blinker with:
- configurable LED count, step rate and PWM resolution;
- four runtime-selectable modes: binary count, Gray count, bouncing scanner and PWM "breathe".

The block sits behind the global clock buffer and drives top-level LED pins directly.

## Interface
- N_LEDS, 4: number of LED outputs; legal range 1..32.
- LOG2DELAY, 21: step period is 2^LOG2DELAY clock cycles; legal range 1..30.
- PWM_BITS, 4: duty/PWM counter width for breathe mode; legal range 1..8.

Ports:
- clki  in  1  clock (post-BUFG).
- rst  in  1  reset, asynchronous, active-high.
- mode  in  2  requested pattern: 0 binary, 1 Gray, 2 scanner, 3 breathe. May change at any time.
- led  out  N_LEDS  pattern output, registered; bit 0 is the LSB / scanner start position.
- step  out  1  high for one cycle when the step counter is at its terminal value, i.e. the cycle before a pattern step.
- mode_q  out  2  currently active mode.

## Operation
- Prescaler pre (LOG2DELAY bits):
  - increments every cycle and wraps.
  - step = (pre == 2^LOG2DELAY-1), combinational from pre.
- Pattern state:
  - cnt (N_LEDS bits): wraps modulo 2^N_LEDS.
  - pos: 0..N_LEDS-1.
  - dir: 0 = up, 1 = down.
  - duty (PWM_BITS bits).
  - ddir: 0 = rising, 1 = falling.
  - pwm (PWM_BITS bits): free-running, +1 every cycle, wraps.
- At a clock edge with step=1:
  - If mode != mode_q: load mode_q <= mode and reset all pattern state (cnt=0, pos=0, dir=0, duty=0, ddir=0). No advance occurs on this edge.
  - Else, advance only the state of the active mode:
    - binary/Gray: cnt <= cnt+1.
    - scanner, N_LEDS=1: pos stays 0.
    - scanner, dir=0: pos+1. If the new pos is N_LEDS-1, dir <= 1.
    - scanner, dir=1: pos-1. If the new pos is 0, dir <= 0.
    - breathe, ddir=0: duty+1. On reaching 2^PWM_BITS-1, ddir <= 1.
    - breathe, ddir=1: duty-1. On reaching 0, ddir <= 0.
- Changes to mode between steps are ignored until the next step edge. Only the value present at the step edge is used.
- LED decode, registered every cycle from the current state:
  - binary: led = cnt.
  - Gray: led = cnt ^ (cnt >> 1).
  - scanner: led = 1 << pos.
  - breathe: all bits = (pwm < duty).
    - duty=0 gives always off.
    - duty=max gives on for 2^PWM_BITS-1 of every 2^PWM_BITS cycles.

## Timing
- Reset values:
  - outputs: led=0, step=0, mode_q=0 (binary).
  - state: pre=0, cnt=0, pos=0, dir=0, duty=0, ddir=0, pwm=0.
- First step asserts in cycle 2^LOG2DELAY-1 after reset release (cycle 0 = first edge after release). Thereafter step asserts every 2^LOG2DELAY cycles.
- State updates on the step edge. led reflects the new state one edge later, giving a 1-cycle latency from the step edge to the led change.
- Mode switch: mode_q updates on the step edge. The first led value of the new mode (the state-0 pattern) appears one edge later. The first advance in the new mode occurs on the following step.
- Reset asserted mid-operation:
  - all registers return to reset values immediately, without waiting for a clock edge.
  - pre restarts from 0 after release; no partial step period is carried over.
- Wrap-around:
  - cnt = 2^N_LEDS-1 steps to 0.
  - pre and pwm wrap silently.
- mode_q never holds a value that was not sampled at a step edge.

## Test plan
All scenarios use N_LEDS=4, LOG2DELAY=2, PWM_BITS=2 unless stated; a step edge occurs every 4 cycles.
- Reset and period: hold mode=0, release rst.
  - Required: led=0000 and mode_q=0 immediately.
  - step high in cycles 3, 7, 11.
  - led becomes 0001 one cycle after the first step edge, then 0010, 0011, … up to 1111, then 0000.
- Gray mode: mode=1 from reset.
  - First step edge switches mode_q to 1, led stays 0000.
  - Subsequent steps give 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100; exactly one bit changes per step.
- Scanner bounce: mode=2.
  - After switch: 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010.
  - With N_LEDS=1: led stays 1.
- Breathe: mode=3.
  - duty sequence per step: 0, 1, 2, 3, 2, 1, 0, 1.
  - At duty=1, led is 1111 for exactly 1 of every 4 cycles. At duty=3, 3 of 4. At duty=0, never.
- Mode change between steps: in binary mode, pulse mode=2 for 2 cycles between step edges, then return to 0.
  - Required: mode_q stays 0 and cnt keeps counting.
  - Then change mode=1 and hold: on the next step edge, mode_q=1 and led=0000 one cycle later.
- Reset mid-operation: assert rst asynchronously mid-cycle in scanner mode with pos=2.
  - led=0000 and mode_q=0 before the next clock edge.
  - After release, the first step occurs in cycle 3.
